prio_arbiter: RTL and testbench

Parametrised, registered successor to the lab 8-to-3 priority encoder. It takes an N-bit request vector and produces the binary index of the winning request plus a `valid` flag. The winner is held until the consumer acknowledges it. Fixed-priority mode reproduces the combinational encoder's result. Round-robin mode rotates priority after each acknowledged grant. It sits between a bank of requesters and a single shared consumer.

---
 rtl/prio_arbiter.sv | 92 +++++++++
 tb/tb_prio_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter: fixed-priority (highest index) or round-robin,
// grant held in y/valid until the consumer acknowledges it.
module prio_arbiter #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         mode,
   input  logic         ack,
   output logic [W-1:0] y,
   output logic         valid
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   y_q, y_d;
   logic [W-1:0]   ptr_q, ptr_d;
   logic           valid_q, valid_d;
   logic [W-1:0]   fixed_win;
   logic [W-1:0]   rr_win;

   // Later iterations overwrite earlier ones, so the highest set index wins.
   always_comb begin
      fixed_win = '0;
      for (int i = 0; i < N; i++) begin
         if (req[i]) fixed_win = W'(i);
      end
   end

   // Distance below ptr, modulo N; ptr itself is searched last (distance N).
   always_comb begin
      int best_d;
      int d;
      rr_win = '0;
      best_d = N + 1;
      for (int i = 0; i < N; i++) begin
         d = int'(ptr_q) - i;
         if (d <= 0) d = d + N;
         if (req[i] && (d < best_d)) begin
            best_d = d;
            rr_win = W'(i);
         end
      end
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      y_d     = y_q;
      ptr_d   = ptr_q;
      valid_d = valid_q;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               y_d     = mode ? rr_win : fixed_win;
               valid_d = 1'b1;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (ack) begin
               valid_d = 1'b0;
               ptr_d   = y_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         y_q     <= '0;
         ptr_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
      end
   end

   assign y     = y_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Scoreboard bench for prio_arbiter (N=8): expected grant indices are queued
// when a request is driven and popped when the grant appears.
module tb_prio_arbiter;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic         mode;
   logic         ack;
   logic [W-1:0] y;
   logic         valid;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   prio_arbiter #(.N(N), .W(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .mode  (mode),
      .ack   (ack),
      .y     (y),
      .valid (valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] pop_exp();
      if (exp_q.size() == 0) return 8'hFF;
      return {5'b0, exp_q.pop_front()};
   endfunction

   // Drive a request at a negedge, expect the grant one edge later, then ack it.
   // req stays driven afterwards so back-to-back calls re-arbitrate on the next edge.
   task automatic serve(input logic [N-1:0] r, input logic m, input logic [W-1:0] e, input string tag);
      req  = r;
      mode = m;
      ack  = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      check({tag, "_valid"}, {7'b0, valid}, 8'd1);
      check({tag, "_y"}, {5'b0, y}, pop_exp());
      ack = 1'b1;
      @(negedge clk);
      check({tag, "_rel"}, {7'b0, valid}, 8'd0);
      ack = 1'b0;
   endtask

   task automatic go_idle();
      req = '0;
      ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [N-1:0] rr_pat [0:8];
      logic [W-1:0] rr_exp [0:8];

      rst  = 1'b1;
      req  = '0;
      mode = 1'b0;
      ack  = 1'b0;
      #1;
      check("rst0_y", {5'b0, y}, 8'd0);
      check("rst0_valid", {7'b0, valid}, 8'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_valid", {7'b0, valid}, 8'd0);

      // One-hot sweep in fixed-priority mode
      for (int i = 0; i < N; i++) serve(8'(1 << i), 1'b0, W'(i), $sformatf("sweep%0d", i));
      go_idle();

      // Requester 0 never wins against 7
      for (int i = 0; i < 4; i++) serve(8'h81, 1'b0, 3'd7, $sformatf("fixed%0d", i));
      go_idle();

      // Mid-cycle reset with a live grant
      req = 8'hFF;
      mode = 1'b0;
      @(negedge clk);
      check("pre_rst_valid", {7'b0, valid}, 8'd1);
      check("pre_rst_y", {5'b0, y}, 8'd7);
      #2 rst = 1'b1;
      #1;
      check("async_rst_y", {5'b0, y}, 8'd0);
      check("async_rst_valid", {7'b0, valid}, 8'd0);
      @(negedge clk);
      check("held_rst_valid", {7'b0, valid}, 8'd0);
      check("held_rst_y", {5'b0, y}, 8'd0);
      req = '0;
      rst = 1'b0;
      @(negedge clk);

      // Round-robin from a freshly reset pointer
      for (int i = 0; i < 9; i++) begin
         rr_pat[i] = 8'hFF;
         rr_exp[i] = (i == 8) ? 3'd7 : W'(7 - i);
      end
      for (int i = 0; i < 9; i++) serve(rr_pat[i], 1'b1, rr_exp[i], $sformatf("rr%0d", i));
      for (int i = 0; i < 4; i++) serve(8'b0010_0100, 1'b1, (i % 2 == 0) ? 3'd5 : 3'd2, $sformatf("rr2_%0d", i));
      go_idle();

      // Sticky grant survives the request dropping
      req  = 8'h08;
      mode = 1'b0;
      exp_q.push_back(3'd3);
      @(negedge clk);
      req = '0;
      check("sticky_y0", {5'b0, y}, pop_exp());
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("sticky_y%0d", i + 1), {5'b0, y}, 8'd3);
         check($sformatf("sticky_v%0d", i + 1), {7'b0, valid}, 8'd1);
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("sticky_rel", {7'b0, valid}, 8'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("stay_idle%0d", i), {7'b0, valid}, 8'd0);
      end

      // Mid-grant reset in round-robin clears the pointer
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      serve(8'hFF, 1'b1, 3'd7, "mrst_g0");
      serve(8'hFF, 1'b1, 3'd6, "mrst_g1");
      exp_q.push_back(3'd5);
      @(negedge clk);
      check("mrst_g2_y", {5'b0, y}, pop_exp());
      check("mrst_g2_valid", {7'b0, valid}, 8'd1);
      #2 rst = 1'b1;
      #1;
      check("mrst_valid", {7'b0, valid}, 8'd0);
      @(negedge clk);
      exp_q.push_back(3'd7);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_valid", {7'b0, valid}, 8'd1);
      check("post_rst_y", {5'b0, y}, pop_exp());
      go_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
